mult_share_arbiter: RTL

- Round-robin arbiter and sequencer that shares one sequential multiplier (WIDTH-bit multiplicand/multiplier, 2*WIDTH-bit product, start/done handshake) between NREQ requesters.
- Captures the winner's operands, pulses the multiplier start, and waits for done with a timeout guard.
- Returns the product, or an error flag on timeout, to the winning requester.
- Sits between client blocks and the multiplier control/datapath pair.

---
 rtl/mult_share_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter that shares one sequential multiplier between NREQ clients.
// Latches the winner's operands, pulses start, waits for done with a timeout guard.
//
// state  | meaning
// IDLE   | no job; choose next requester round-robin from rr_ptr
// ISSUE  | one cycle: grant pulse and multiplier start
// WAIT   | count cycles until mul_done or timeout
// RESP   | one cycle: response pulse to the winner, advance rr_ptr
module mult_share_arbiter #(
    parameter int WIDTH   = 4,
    parameter int NREQ    = 3,
    parameter int TIMEOUT = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] md_in,
    input  logic [NREQ*WIDTH-1:0] mr_in,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [2*WIDTH-1:0]    rsp_product,
    output logic                  rsp_err,
    output logic                  busy,
    output logic                  mul_start,
    output logic [WIDTH-1:0]      mul_md,
    output logic [WIDTH-1:0]      mul_mr,
    input  logic                  mul_done,
    input  logic [2*WIDTH-1:0]    mul_product
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   rr_ptr, winner, pick;
    logic            found;
    logic [CW-1:0]   cnt;
    logic            err_flag;
    logic            timeout_hit;
    logic [WIDTH-1:0] md_arr [NREQ];
    logic [WIDTH-1:0] mr_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign md_arr[i] = md_in[i*WIDTH +: WIDTH];
        assign mr_arr[i] = mr_in[i*WIDTH +: WIDTH];
    end

    // First set request at or above rr_ptr, wrapping past NREQ-1 back to 0.
    always_comb begin
        logic [IW:0]   sum;
        logic [IW-1:0] cand;
        found = 1'b0;
        pick  = '0;
        sum   = '0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, rr_ptr} + (IW+1)'(k);
            if (sum >= (IW+1)'(NREQ)) begin
                sum = sum - (IW+1)'(NREQ);
            end
            cand = sum[IW-1:0];
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (found) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (mul_done || timeout_hit) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        gnt       = '0;
        rsp_valid = '0;
        mul_start = 1'b0;
        rsp_err   = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_ISSUE: begin
                gnt[winner] = 1'b1;
                mul_start   = 1'b1;
            end
            S_RESP: begin
                rsp_valid[winner] = 1'b1;
                rsp_err           = err_flag;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr      <= '0;
            winner      <= '0;
            cnt         <= '0;
            mul_md      <= '0;
            mul_mr      <= '0;
            rsp_product <= '0;
            err_flag    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        winner <= pick;
                        mul_md <= md_arr[pick];
                        mul_mr <= mr_arr[pick];
                    end
                end
                S_ISSUE: cnt <= '0;
                S_WAIT: begin
                    cnt <= cnt + 1'b1;
                    // Done takes priority over a simultaneous timeout.
                    if (mul_done) begin
                        rsp_product <= mul_product;
                        err_flag    <= 1'b0;
                    end else if (timeout_hit) begin
                        rsp_product <= '0;
                        err_flag    <= 1'b1;
                    end
                end
                S_RESP: rr_ptr <= (winner == IW'(NREQ - 1)) ? '0 : winner + 1'b1;
                default: ;
            endcase
        end
    end

endmodule
